// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with 3-sample majority voting, parity/framing/break
// detection and a valid/ready output stage that flags overruns.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUDRATE   = 300000,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    input  logic                 i_rx_ready,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break_det,
    output logic                 o_overrun_err,
    output logic                 o_busy
);

    localparam int DIV = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int IW  = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TICK_LAST     = TW'(DIV - 1);
    localparam logic [SW-1:0] SC_A          = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SC_B          = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SC_C          = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SC_LAST       = SW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_PARITY   = 3'd3;
    localparam logic [2:0] S_STOP     = 3'd4;
    localparam logic [2:0] S_BRK_WAIT = 3'd5;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [TW-1:0]        r_tick_cnt;
    logic [2:0]           r_state;
    logic [SW-1:0]        r_sc;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_samp_a;
    logic                 r_samp_b;
    logic                 r_par_bit;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_armed;

    logic w_rx_s;
    logic w_tick;
    logic w_maj;
    logic w_decide;
    logic w_wrap;
    logic w_par_calc;
    logic w_brk;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    assign w_rx_s     = r_sync2;
    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_maj      = (r_samp_a & r_samp_b) | (r_samp_a & w_rx_s) | (r_samp_b & w_rx_s);
    assign w_decide   = w_tick && (r_sc == SC_C);
    assign w_wrap     = w_tick && (r_sc == SC_LAST);
    assign w_par_calc = (PARITY == 1) ? ~(^r_shift) : (^r_shift);
    // A break is an all-zero frame whose parity bit (if any) and first stop bit are also 0.
    assign w_brk      = (r_shift == '0) && ((PARITY == 0) || !r_par_bit) && !w_maj;
    assign o_busy     = (r_state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_sc          <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_samp_a      <= 1'b0;
            r_samp_b      <= 1'b0;
            r_par_bit     <= 1'b0;
            r_perr        <= 1'b0;
            r_ferr        <= 1'b0;
            r_armed       <= 1'b0;
            o_rx_data     <= '0;
            o_rx_valid    <= 1'b0;
            o_parity_err  <= 1'b0;
            o_frame_err   <= 1'b0;
            o_break_det   <= 1'b0;
            o_overrun_err <= 1'b0;
        end else begin
            o_break_det   <= 1'b0;
            o_overrun_err <= 1'b0;
            if (o_rx_valid && i_rx_ready)
                o_rx_valid <= 1'b0;

            if (w_tick && (r_sc == SC_A))
                r_samp_a <= w_rx_s;
            if (w_tick && (r_sc == SC_B))
                r_samp_b <= w_rx_s;
            if (w_tick && (r_state != S_IDLE) && (r_state != S_BRK_WAIT))
                r_sc <= (r_sc == SC_LAST) ? '0 : r_sc + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= S_START;
                        r_sc    <= '0;
                        r_idx   <= '0;
                        r_perr  <= 1'b0;
                        r_ferr  <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_decide && w_maj)
                        r_state <= S_IDLE;
                    else if (w_wrap)
                        r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_decide)
                        r_shift[r_idx] <= w_maj;
                    if (w_wrap) begin
                        if (r_idx == IDX_DATA_LAST) begin
                            r_idx   <= '0;
                            r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_decide) begin
                        r_par_bit <= w_maj;
                        r_perr    <= (w_maj != w_par_calc);
                    end
                    if (w_wrap)
                        r_state <= S_STOP;
                end
                S_STOP: begin
                    // The frame closes at the last stop bit's decision point so the next start edge is seen.
                    if (w_decide) begin
                        if ((r_idx == '0) && w_brk) begin
                            o_break_det <= 1'b1;
                            r_state     <= S_BRK_WAIT;
                        end else if (r_idx == IDX_STOP_LAST) begin
                            r_state <= S_IDLE;
                            if (!o_rx_valid || i_rx_ready) begin
                                o_rx_data    <= r_shift;
                                o_parity_err <= r_perr;
                                o_frame_err  <= r_ferr | ~w_maj;
                                o_rx_valid   <= 1'b1;
                            end else begin
                                o_overrun_err <= 1'b1;
                            end
                        end else begin
                            r_ferr <= r_ferr | ~w_maj;
                        end
                    end else if (w_wrap) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_BRK_WAIT: begin
                    if (w_rx_s)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
